// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - MIPS32 register file with write bypass, busy scoreboard and post-reset clear sequencer
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       mark_we,
  input  logic [ADDR_W-1:0]          mark_addr,
  input  logic                       flush,
  output logic                       ready,
  output logic [ADDR_W-1:0]          clr_ptr_o
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG - 1);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [DATA_W-1:0]   mem [NREG];
  logic [NREG-1:0]     busy;
  logic [NREG-1:0]     busy_nxt;
  logic                wr_ok;
  logic                mark_ok;

  // Requests arriving while the sequencer is still clearing are dropped.
  assign wr_ok     = ready && we && (wr_addr != '0);
  assign mark_ok   = ready && mark_we && (mark_addr != '0);
  assign clr_ptr_o = clr_ptr;

  // Order matters: flush first, then the write retires, then a new issue re-marks.
  always_comb begin
    busy_nxt = busy;
    if (ready && flush) begin
      busy_nxt = '0;
    end
    if (wr_ok) begin
      busy_nxt[wr_addr] = 1'b0;
    end
    if (mark_ok) begin
      busy_nxt[mark_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
      busy    <= '0;
    end else begin
      case (state)
        CLEAR: begin
          mem[clr_ptr] <= '0;
          if (clr_ptr == LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
          end
        end
        RUN: begin
          if (wr_ok) begin
            mem[wr_addr] <= wr_data;
          end
          busy <= busy_nxt;
        end
        default: begin
          state <= CLEAR;
          ready <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              bsy;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    // Reads are forced to zero/not-busy until the array is fully cleared.
    always_comb begin
      data = '0;
      bsy  = 1'b0;
      if (ready && (addr != '0)) begin
        if ((BYPASS != 0) && we && (wr_addr == addr)) begin
          data = wr_data;
          bsy  = 1'b0;
        end else begin
          data = mem[addr];
          bsy  = busy[addr];
        end
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = data;
    assign rd_busy[i]                  = bsy;
  end

endmodule
